// File: rtl/pov_sweep_renderer.sv
// Column renderer for the spinning POV LED bar: turns a packed BCD digit string
// into a timed sequence of LED columns, started by the encoder index pulse.
module pov_sweep_renderer #(
  parameter int NUM_LEDS       = 8,
  parameter int NUM_DIGITS     = 6,
  parameter int CLKS_PER_PIXEL = 500000,
  parameter int FRONT_PAD      = 10,
  parameter int INTER_COL      = 1,
  parameter int GROUP          = 2,
  parameter int DIGIT_PAD      = 2,
  parameter int COLOR_W        = 8
) (
  input  logic                          board_clk,
  input  logic                          Reset,
  input  logic                          index_n,
  input  logic                          enable,
  input  logic [4*NUM_DIGITS-1:0]       digits,
  input  logic [COLOR_W-1:0]            col_r,
  input  logic [COLOR_W-1:0]            col_g,
  input  logic [COLOR_W-1:0]            col_b,
  input  logic                          overrun_clr,
  output logic [NUM_LEDS*COLOR_W-1:0]   led_r,
  output logic [NUM_LEDS*COLOR_W-1:0]   led_g,
  output logic [NUM_LEDS*COLOR_W-1:0]   led_b,
  output logic                          pixel_strobe,
  output logic                          busy,
  output logic                          overrun
);

  localparam int FRONT_COLS = (FRONT_PAD > 0) ? FRONT_PAD : 1;
  localparam int GLYPH_COLS = 5 + INTER_COL;
  localparam int GAP_COLS   = (DIGIT_PAD > 0) ? DIGIT_PAD : 1;
  localparam int COL_MAX    = (FRONT_COLS > GLYPH_COLS) ?
                              ((FRONT_COLS > GAP_COLS) ? FRONT_COLS : GAP_COLS) :
                              ((GLYPH_COLS > GAP_COLS) ? GLYPH_COLS : GAP_COLS);
  localparam int COL_W = $clog2(COL_MAX);
  localparam int PC_W  = $clog2(CLKS_PER_PIXEL);
  localparam int DIG_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int GRP_W = (GROUP > 1) ? $clog2(GROUP) : 1;

  localparam logic [PC_W-1:0]  PC_LAST    = PC_W'(CLKS_PER_PIXEL - 1);
  localparam logic [COL_W-1:0] FRONT_LAST = COL_W'(FRONT_COLS - 1);
  localparam logic [COL_W-1:0] GLYPH_LAST = COL_W'(GLYPH_COLS - 1);
  localparam logic [COL_W-1:0] GAP_LAST   = COL_W'(GAP_COLS - 1);
  localparam logic [DIG_W-1:0] DIG_LAST   = DIG_W'(NUM_DIGITS - 1);
  localparam logic [GRP_W-1:0] GRP_LAST   = GRP_W'(GROUP - 1);

  typedef enum logic [1:0] {IDLE, FRONT, GLYPH, GAP} state_t;

  // Five 7-bit columns per glyph, column c at [c*7 +: 7]; bit r lights LED NUM_LEDS-1-r.
  function automatic logic [6:0] font_col(input logic [3:0] d, input logic [2:0] c);
    logic [34:0] g;
    case (d)
      4'h0:    g = {7'h3E, 7'h51, 7'h49, 7'h45, 7'h3E};
      4'h1:    g = {7'h00, 7'h00, 7'h42, 7'h7F, 7'h40};
      4'h2:    g = {7'h42, 7'h61, 7'h51, 7'h49, 7'h46};
      4'h3:    g = {7'h22, 7'h49, 7'h49, 7'h49, 7'h36};
      4'h4:    g = {7'h18, 7'h14, 7'h12, 7'h7F, 7'h10};
      4'h5:    g = {7'h2F, 7'h49, 7'h49, 7'h49, 7'h31};
      4'h6:    g = {7'h3E, 7'h49, 7'h49, 7'h49, 7'h32};
      4'h7:    g = {7'h01, 7'h01, 7'h71, 7'h09, 7'h07};
      4'h8:    g = {7'h36, 7'h49, 7'h49, 7'h49, 7'h36};
      4'h9:    g = {7'h26, 7'h49, 7'h49, 7'h49, 7'h3E};
      4'hA:    g = {7'h00, 7'h00, 7'h36, 7'h36, 7'h00};
      default: g = '0;
    endcase
    return g[int'(c)*7 +: 7];
  endfunction

  logic                    sync1_q, sync1_d, sync2_q, sync2_d, prev_q, prev_d;
  state_t                  state_q, state_d;
  logic [PC_W-1:0]         pc_q, pc_d;
  logic [COL_W-1:0]        col_q, col_d;
  logic [DIG_W-1:0]        dig_q, dig_d;
  logic [GRP_W-1:0]        grp_q, grp_d;
  logic [6:0]              bits_q, bits_d;
  logic                    strobe_q, strobe_d;
  logic                    overrun_q, overrun_d;
  logic [4*NUM_DIGITS-1:0] snap_dig_q, snap_dig_d;
  logic [COLOR_W-1:0]      snap_r_q, snap_r_d, snap_g_q, snap_g_d, snap_b_q, snap_b_d;
  logic                    trig, tick;

  assign busy = (state_q != IDLE);
  assign trig = enable & prev_q & ~sync2_q;
  assign tick = busy && (pc_q == PC_LAST);

  always_comb begin
    // NOTE: every variable gets its hold value first, so no path through the
    // branches below can leave one unassigned and infer a latch.
    sync1_d    = index_n;
    sync2_d    = sync1_q;
    prev_d     = sync2_q;
    state_d    = state_q;
    pc_d       = pc_q;
    col_d      = col_q;
    dig_d      = dig_q;
    grp_d      = grp_q;
    bits_d     = bits_q;
    strobe_d   = 1'b0;
    overrun_d  = overrun_q & ~overrun_clr;
    snap_dig_d = snap_dig_q;
    snap_r_d   = snap_r_q;
    snap_g_d   = snap_g_q;
    snap_b_d   = snap_b_q;

    if (trig) begin
      // A retrigger wins over a tick and over overrun_clr on the same edge.
      if (busy) overrun_d = 1'b1;
      snap_dig_d = digits;
      snap_r_d   = col_r;
      snap_g_d   = col_g;
      snap_b_d   = col_b;
      state_d    = FRONT;
      pc_d       = '0;
      col_d      = '0;
      dig_d      = '0;
      grp_d      = '0;
      bits_d     = '0;
      strobe_d   = 1'b1;
    end else if (busy) begin
      pc_d = tick ? '0 : pc_q + 1'b1;
      if (tick) begin
        strobe_d = 1'b1;
        col_d    = col_q + 1'b1;
        case (state_q)
          FRONT: if (col_q == FRONT_LAST) begin
            state_d = GLYPH;
            col_d   = '0;
          end
          GLYPH: if (col_q == GLYPH_LAST) begin
            col_d = '0;
            if (dig_q == DIG_LAST) begin
              state_d = IDLE;
            end else begin
              dig_d = dig_q + 1'b1;
              if (grp_q == GRP_LAST) begin
                grp_d = '0;
                if (DIGIT_PAD > 0) state_d = GAP;
              end else begin
                grp_d = grp_q + 1'b1;
              end
            end
          end
          GAP: if (col_q == GAP_LAST) begin
            state_d = GLYPH;
            col_d   = '0;
          end
          default: state_d = IDLE;
        endcase
        if (state_d == GLYPH && col_d < COL_W'(5))
          bits_d = font_col(snap_dig_q[int'(dig_d)*4 +: 4], col_d[2:0]);
        else
          bits_d = '0;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge value of every other flop.
  always_ff @(posedge board_clk or posedge Reset) begin
    if (Reset) begin
      sync1_q    <= 1'b0;
      sync2_q    <= 1'b0;
      prev_q     <= 1'b0;
      state_q    <= IDLE;
      pc_q       <= '0;
      col_q      <= '0;
      dig_q      <= '0;
      grp_q      <= '0;
      bits_q     <= '0;
      strobe_q   <= 1'b0;
      overrun_q  <= 1'b0;
      // NOTE: the snapshot is reset as well, so no stale colour can ever reach
      // the LED outputs after reset.
      snap_dig_q <= '0;
      snap_r_q   <= '0;
      snap_g_q   <= '0;
      snap_b_q   <= '0;
    end else begin
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      prev_q     <= prev_d;
      state_q    <= state_d;
      pc_q       <= pc_d;
      col_q      <= col_d;
      dig_q      <= dig_d;
      grp_q      <= grp_d;
      bits_q     <= bits_d;
      strobe_q   <= strobe_d;
      overrun_q  <= overrun_d;
      snap_dig_q <= snap_dig_d;
      snap_r_q   <= snap_r_d;
      snap_g_q   <= snap_g_d;
      snap_b_q   <= snap_b_d;
    end
  end

  assign pixel_strobe = strobe_q;
  assign overrun      = overrun_q;

  // The snapshot colour only changes while bits_q is cleared, so outputs stay clean.
  always_comb begin
    led_r = '0;
    led_g = '0;
    led_b = '0;
    for (int r = 0; r < 7; r++) begin
      if (bits_q[r]) begin
        led_r[(NUM_LEDS-1-r)*COLOR_W +: COLOR_W] = snap_r_q;
        led_g[(NUM_LEDS-1-r)*COLOR_W +: COLOR_W] = snap_g_q;
        led_b[(NUM_LEDS-1-r)*COLOR_W +: COLOR_W] = snap_b_q;
      end
    end
  end

endmodule
